// File: rtl/tuner_pwr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tuner_pwr_sweep_ctrl
// Brief   : Heater DAC code sweep with power-read handshake and peak tracking.
// Revision: 1.0
// ============================================================================
module tuner_pwr_sweep_ctrl #(
    parameter int ADC_WIDTH = 8,
    parameter int DAC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sweep_start,
    input  logic                 i_sweep_abort,
    input  logic [DAC_WIDTH-1:0] i_code_start,
    input  logic [DAC_WIDTH-1:0] i_code_end,
    input  logic [DAC_WIDTH-1:0] i_code_step,
    output logic [DAC_WIDTH-1:0] o_dac_code,
    output logic                 o_pwr_read_val,
    input  logic                 i_pwr_read_rdy,
    input  logic                 i_pwr_detect_val,
    output logic                 o_pwr_detect_rdy,
    input  logic [ADC_WIDTH-1:0] i_pwr_detect_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_peak_valid,
    output logic [ADC_WIDTH-1:0] o_peak_pwr,
    output logic [DAC_WIDTH-1:0] o_peak_code
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DAC_WIDTH-1:0] r_code_end;
    logic [DAC_WIDTH-1:0] r_step;
    logic [DAC_WIDTH-1:0] r_dac_code;
    logic [ADC_WIDTH-1:0] r_pwr_q;
    logic [ADC_WIDTH-1:0] r_peak_pwr;
    logic [DAC_WIDTH-1:0] r_peak_code;
    logic                 r_first;
    logic                 r_err;
    logic                 r_done;
    logic                 r_peak_valid;

    logic                 w_read_fire;
    logic                 w_detect_fire;
    logic                 w_start;
    logic                 w_range_err;
    logic [DAC_WIDTH-1:0] w_step_eff;
    logic [DAC_WIDTH:0]   w_next_code;
    logic                 w_last_point;

    assign o_pwr_read_val   = (r_state == S_REQ);
    assign o_pwr_detect_rdy = (r_state == S_WAIT);
    assign o_busy           = (r_state != S_IDLE);
    assign o_dac_code       = r_dac_code;
    assign o_done           = r_done;
    assign o_err            = r_err;
    assign o_peak_valid     = r_peak_valid;
    assign o_peak_pwr       = r_peak_pwr;
    assign o_peak_code      = r_peak_code;

    assign w_read_fire   = o_pwr_read_val & i_pwr_read_rdy;
    assign w_detect_fire = i_pwr_detect_val & o_pwr_detect_rdy;
    assign w_start       = i_sweep_start & ~i_sweep_abort & (r_state == S_IDLE);
    assign w_range_err   = (i_code_start > i_code_end);
    assign w_step_eff    = (i_code_step == '0) ? {{(DAC_WIDTH-1){1'b0}}, 1'b1} : i_code_step;

    // The extra carry bit keeps a step past the top code from wrapping around.
    assign w_next_code  = {1'b0, r_dac_code} + {1'b0, r_step};
    assign w_last_point = (w_next_code > {1'b0, r_code_end});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_sweep_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (i_sweep_start && !w_range_err) w_next_state = S_REQ;
                S_REQ:    if (w_read_fire) w_next_state = S_WAIT;
                S_WAIT:   if (w_detect_fire) w_next_state = S_UPDATE;
                S_UPDATE: w_next_state = w_last_point ? S_DONE : S_REQ;
                S_DONE:   w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code_end   <= '0;
            r_step       <= '0;
            r_dac_code   <= '0;
            r_pwr_q      <= '0;
            r_peak_pwr   <= '0;
            r_peak_code  <= '0;
            r_first      <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_peak_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_sweep_abort) begin
                r_peak_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_code_end   <= i_code_end;
                            r_step       <= w_step_eff;
                            r_peak_valid <= 1'b0;
                            r_err        <= w_range_err;
                            if (w_range_err) begin
                                r_done <= 1'b1;
                            end else begin
                                r_dac_code  <= i_code_start;
                                r_peak_pwr  <= '0;
                                r_peak_code <= '0;
                                r_first     <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (w_detect_fire) r_pwr_q <= i_pwr_detect_data;
                    end
                    S_UPDATE: begin
                        // Strict compare so a tie keeps the earliest (lowest) code.
                        if (r_first || (r_pwr_q > r_peak_pwr)) begin
                            r_peak_pwr  <= r_pwr_q;
                            r_peak_code <= r_dac_code;
                        end
                        r_first <= 1'b0;
                        if (w_last_point) begin
                            r_done <= 1'b1;
                        end else begin
                            r_dac_code <= w_next_code[DAC_WIDTH-1:0];
                        end
                    end
                    S_DONE: begin
                        r_peak_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tuner_pwr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tuner_pwr_sweep_ctrl
// Brief   : Directed self-checking bench for the power sweep controller.
// Revision: 1.0
// ============================================================================
module tb_tuner_pwr_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sweep_start, sweep_abort;
    logic [7:0] code_start, code_end, code_step;
    logic [7:0] dac_code;
    logic       read_val, read_rdy, detect_val, detect_rdy;
    logic [7:0] detect_data;
    logic       busy, done, err, peak_valid;
    logic [7:0] peak_pwr, peak_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tuner_pwr_sweep_ctrl #(.ADC_WIDTH(8), .DAC_WIDTH(8)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_sweep_start     (sweep_start),
        .i_sweep_abort     (sweep_abort),
        .i_code_start      (code_start),
        .i_code_end        (code_end),
        .i_code_step       (code_step),
        .o_dac_code        (dac_code),
        .o_pwr_read_val    (read_val),
        .i_pwr_read_rdy    (read_rdy),
        .i_pwr_detect_val  (detect_val),
        .o_pwr_detect_rdy  (detect_rdy),
        .i_pwr_detect_data (detect_data),
        .o_busy            (busy),
        .o_done            (done),
        .o_err             (err),
        .o_peak_valid      (peak_valid),
        .o_peak_pwr        (peak_pwr),
        .o_peak_code       (peak_code)
    );

    // PHY model for one point: waits for the request, notes the applied code,
    // then returns pwr after lat cycles. Starts and ends on a negedge.
    task automatic phy_point(input logic [7:0] pwr, input int lat,
                             output logic [7:0] code, output bit ok);
        int t;
        ok   = 1'b1;
        code = 8'd0;
        t    = 0;
        while (!read_val && t < 50) begin @(negedge clk); t++; end
        if (!read_val) begin ok = 1'b0; return; end
        code = dac_code;
        @(negedge clk);
        repeat (lat) @(negedge clk);
        detect_val  = 1'b1;
        detect_data = pwr;
        t = 0;
        while (!detect_rdy && t < 50) begin @(negedge clk); t++; end
        if (!detect_rdy) ok = 1'b0;
        @(negedge clk);
        detect_val  = 1'b0;
        detect_data = 8'd0;
    endtask

    task automatic start_sweep(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st);
        sweep_start = 1'b1;
        code_start  = s;
        code_end    = e;
        code_step   = st;
        @(negedge clk);
        sweep_start = 1'b0;
    endtask

    task automatic count_tail(input int cycles, output int n_done, output int n_req);
        n_done = 0;
        n_req  = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n_done++;
            if (read_val) n_req++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, err, peak_valid, read_val, detect_rdy} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                               {busy, done, err, peak_valid, read_val, detect_rdy});
        end
        n_tests++;
        if ({dac_code, peak_pwr, peak_code} !== 24'd0) begin
            n_fail++; $display("FAIL reset_values: got %h expected 000000", {dac_code, peak_pwr, peak_code});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_basic;
        logic [7:0] pw [3];
        logic [7:0] ex [3];
        logic [7:0] c;
        bit ok;
        int nd, nr;
        pw = '{8'd5, 8'd9, 8'd3};
        ex = '{8'd10, 8'd12, 8'd14};
        start_sweep(8'd10, 8'd14, 8'd2);
        for (int i = 0; i < 3; i++) begin
            phy_point(pw[i], 2, c, ok);
            n_tests++;
            if (!ok || c !== ex[i]) begin
                n_fail++; $display("FAIL basic_code%0d: got %0d ok=%0d expected %0d", i, c, ok, ex[i]);
            end
        end
        count_tail(4, nd, nr);
        n_tests++;
        if (nd != 1 || nr != 0) begin
            n_fail++; $display("FAIL basic_done: done pulses %0d reqs %0d expected 1 and 0", nd, nr);
        end
        n_tests++;
        if (peak_code !== 8'd12 || peak_pwr !== 8'd9 || peak_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_peak: got code %0d pwr %0d valid %b expected 12 9 1",
                               peak_code, peak_pwr, peak_valid);
        end
        n_tests++;
        if (dac_code !== 8'd14 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_hold: got dac %0d busy %b expected 14 0", dac_code, busy);
        end
    endtask

    task automatic test_tie;
        logic [7:0] pw [3];
        logic [7:0] c;
        bit ok;
        int nd, nr;
        pw = '{8'd7, 8'd7, 8'd4};
        start_sweep(8'd0, 8'd2, 8'd1);
        n_tests++;
        if (peak_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL tie_start: got valid %b busy %b expected 0 1", peak_valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            phy_point(pw[i], 0, c, ok);
            n_tests++;
            if (!ok || c !== i[7:0]) begin
                n_fail++; $display("FAIL tie_code%0d: got %0d ok=%0d expected %0d", i, c, ok, i);
            end
        end
        count_tail(4, nd, nr);
        n_tests++;
        if (peak_code !== 8'd0 || peak_pwr !== 8'd7 || nd != 1) begin
            n_fail++; $display("FAIL tie_peak: got code %0d pwr %0d done %0d expected 0 7 1",
                               peak_code, peak_pwr, nd);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] c;
        bit ok;
        int nd, nr;
        start_sweep(8'd250, 8'd255, 8'd4);
        phy_point(8'd1, 1, c, ok);
        n_tests++;
        if (!ok || c !== 8'd250) begin n_fail++; $display("FAIL ovf_code0: got %0d expected 250", c); end
        phy_point(8'd2, 1, c, ok);
        n_tests++;
        if (!ok || c !== 8'd254) begin n_fail++; $display("FAIL ovf_code1: got %0d expected 254", c); end
        count_tail(5, nd, nr);
        n_tests++;
        if (nd != 1 || nr != 0 || dac_code !== 8'd254) begin
            n_fail++; $display("FAIL ovf_end: done %0d reqs %0d dac %0d expected 1 0 254", nd, nr, dac_code);
        end
        n_tests++;
        if (peak_code !== 8'd254 || peak_pwr !== 8'd2) begin
            n_fail++; $display("FAIL ovf_peak: got code %0d pwr %0d expected 254 2", peak_code, peak_pwr);
        end
    endtask

    task automatic test_err;
        int nb;
        start_sweep(8'd20, 8'd10, 8'd1);
        n_tests++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse: got done %b err %b busy %b expected 1 1 0", done, err, busy);
        end
        nb = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) nb++;
        end
        n_tests++;
        if (nb != 0 || err !== 1'b1 || peak_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_after: busy/done cycles %0d err %b valid %b expected 0 1 0",
                               nb, err, peak_valid);
        end
    endtask

    task automatic test_rdy_stall;
        logic [7:0] c;
        bit ok;
        int t, bad, nd, nr;
        read_rdy = 1'b0;
        start_sweep(8'd5, 8'd5, 8'd1);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL stall_err_clear: got %b expected 0", err); end
        t = 0;
        while (!read_val && t < 20) begin @(negedge clk); t++; end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (read_val !== 1'b1 || dac_code !== 8'd5 || detect_rdy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_hold: unstable cycles %0d expected 0", bad); end
        read_rdy = 1'b1;
        phy_point(8'd40, 1, c, ok);
        count_tail(4, nd, nr);
        n_tests++;
        if (!ok || c !== 8'd5 || nd != 1 || peak_code !== 8'd5 || peak_pwr !== 8'd40) begin
            n_fail++; $display("FAIL stall_result: ok %0d code %0d done %0d peak %0d/%0d expected 1 5 1 5/40",
                               ok, c, nd, peak_code, peak_pwr);
        end
    endtask

    task automatic test_abort;
        logic [7:0] c;
        bit ok;
        int t, nd, nr;
        start_sweep(8'd0, 8'd5, 8'd1);
        phy_point(8'd50, 0, c, ok);
        t = 0;
        while (!read_val && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        n_tests++;
        if (detect_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_in_wait: rdy %b expected 1", detect_rdy); end
        sweep_abort = 1'b1;
        @(negedge clk);
        sweep_abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || peak_valid !== 1'b0 || dac_code !== 8'd1) begin
            n_fail++; $display("FAIL abort_idle: busy %b done %b valid %b dac %0d expected 0 0 0 1",
                               busy, done, peak_valid, dac_code);
        end
        count_tail(3, nd, nr);
        n_tests++;
        if (nd != 0 || nr != 0) begin
            n_fail++; $display("FAIL abort_quiet: done %0d reqs %0d expected 0 0", nd, nr);
        end
        start_sweep(8'd3, 8'd3, 8'd1);
        phy_point(8'd17, 2, c, ok);
        count_tail(4, nd, nr);
        n_tests++;
        if (!ok || c !== 8'd3 || nd != 1 || peak_code !== 8'd3 || peak_pwr !== 8'd17 || peak_valid !== 1'b1) begin
            n_fail++; $display("FAIL abort_restart: code %0d done %0d peak %0d/%0d valid %b expected 3 1 3/17 1",
                               c, nd, peak_code, peak_pwr, peak_valid);
        end
    endtask

    task automatic test_step_zero;
        logic [7:0] c0, c1;
        bit ok0, ok1;
        int nd, nr;
        start_sweep(8'd0, 8'd1, 8'd0);
        phy_point(8'd8, 0, c0, ok0);
        phy_point(8'd6, 0, c1, ok1);
        count_tail(4, nd, nr);
        n_tests++;
        if (!ok0 || !ok1 || c0 !== 8'd0 || c1 !== 8'd1 || nd != 1 || peak_code !== 8'd0 || peak_pwr !== 8'd8) begin
            n_fail++; $display("FAIL step_zero: codes %0d,%0d done %0d peak %0d/%0d expected 0,1 1 0/8",
                               c0, c1, nd, peak_code, peak_pwr);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] c;
        bit ok;
        start_sweep(8'd10, 8'd14, 8'd2);
        phy_point(8'd33, 0, c, ok);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, read_val, detect_rdy, dac_code, peak_pwr, peak_code} !== 27'd0) begin
            n_fail++; $display("FAIL reset_mid: got busy %b dac %0d peak %0d/%0d expected all 0",
                               busy, dac_code, peak_pwr, peak_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        code_start  = 8'd0;
        code_end    = 8'd0;
        code_step   = 8'd0;
        read_rdy    = 1'b1;
        detect_val  = 1'b0;
        detect_data = 8'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie();
        test_overflow();
        test_err();
        test_rdy_stall();
        test_abort();
        test_step_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
